ysyx_23060184_csr_unit: RTL

YSYX_23060184_CSR_UNIT -- requirements
Module: ysyx_23060184_csr_unit

---
 rtl/ysyx_23060184_csr_pkg.sv | 37 +++
 rtl/ysyx_23060184_csr_counter.sv | 37 +++
 rtl/ysyx_23060184_csr_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060184_csr_pkg.sv
// Shared constants for the machine-mode CSR unit: addresses, op encodings,
// trap cause codes and status/interrupt bit positions.
package ysyx_23060184_csr_pkg;

    localparam int unsigned CSR_AW = 12;
    localparam int unsigned CNT_W  = 64;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MIE       = 12'h304;
    localparam logic [CSR_AW-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_AW-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MIP       = 12'h344;
    localparam logic [CSR_AW-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_AW-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_AW-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_AW-1:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int unsigned MCAUSE_M_TIMER = 7;
    localparam int unsigned MCAUSE_ECALL_M = 11;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_LO   = 11;
    localparam int unsigned MSTATUS_MPP_HI   = 12;
    localparam int unsigned MIE_MTIE_BIT     = 7;
    localparam int unsigned MIP_MTIP_BIT     = 7;

endpackage

// File: rtl/ysyx_23060184_csr_counter.sv
// 64-bit free-running counter with independent half writes; a write to either
// half replaces the increment for that cycle and leaves the other half as is.
module ysyx_23060184_csr_counter
    import ysyx_23060184_csr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned HALF = CNT_W / 2;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) count_d[HALF-1:0]     = wdata[HALF-1:0];
            if (wr_hi) count_d[CNT_W-1:HALF] = wdata[CNT_W-1:HALF];
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/ysyx_23060184_csr_unit.sv
// Machine-mode CSR file with timer interrupt, ecall/mret trap handling and
// mcycle/minstret counters; reads and redirects are combinational.
module ysyx_23060184_csr_unit
    import ysyx_23060184_csr_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned HAS_COUNTERS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_valid,
    input  logic [1:0]        csr_op,
    input  logic [CSR_AW-1:0] csr_addr,
    input  logic [XLEN-1:0]   csr_wsrc,
    input  logic              ecall,
    input  logic              mret,
    input  logic [XLEN-1:0]   pc,
    input  logic              irq_timer,
    output logic [XLEN-1:0]   csr_rdata,
    output logic              redirect,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              illegal
);

    logic            st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
    logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
    logic [CNT_W-1:0] mcycle, minstret, cnt_wdata;
    logic            mcycle_wr_lo, mcycle_wr_hi, minstret_wr_lo, minstret_wr_hi;
    logic [XLEN-1:0] old_val, wval, mcause_irq;
    logic            addr_ok, ok, irq_take, ecall_take, trap, mret_take, do_write;
    logic [CSR_AW-1:0] cycle_hi_addr, instret_hi_addr;
    csr_op_e         op;

    assign op = csr_op_e'(csr_op);
    // On RV64 the high counter half lives in the same CSR as the low half
    assign cycle_hi_addr   = (XLEN == 64) ? CSR_MCYCLE   : CSR_MCYCLEH;
    assign instret_hi_addr = (XLEN == 64) ? CSR_MINSTRET : CSR_MINSTRETH;

    // Read mux: pre-update value, zero for unimplemented addresses
    always_comb begin
        old_val = '0;
        addr_ok = 1'b1;
        case (csr_addr)
            CSR_MSTATUS: begin
                old_val[MSTATUS_MIE_BIT]                = st_mie_q;
                old_val[MSTATUS_MPIE_BIT]               = st_mpie_q;
                old_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
            end
            CSR_MIE:      old_val = mie_q;
            CSR_MTVEC:    old_val = mtvec_q;
            CSR_MSCRATCH: old_val = mscratch_q;
            CSR_MEPC:     old_val = mepc_q;
            CSR_MCAUSE:   old_val = mcause_q;
            CSR_MIP:      old_val[MIP_MTIP_BIT] = irq_timer;
            CSR_MCYCLE: begin
                if (HAS_COUNTERS != 0) old_val = XLEN'(mcycle);
                else                   addr_ok = 1'b0;
            end
            CSR_MINSTRET: begin
                if (HAS_COUNTERS != 0) old_val = XLEN'(minstret);
                else                   addr_ok = 1'b0;
            end
            CSR_MCYCLEH: begin
                if (HAS_COUNTERS != 0 && XLEN == 32) old_val = XLEN'(mcycle[CNT_W-1:32]);
                else                                 addr_ok = 1'b0;
            end
            CSR_MINSTRETH: begin
                if (HAS_COUNTERS != 0 && XLEN == 32) old_val = XLEN'(minstret[CNT_W-1:32]);
                else                                 addr_ok = 1'b0;
            end
            default: addr_ok = 1'b0;
        endcase
    end

    assign csr_rdata = old_val;

    // Commit qualification and priority: interrupt > ecall > mret > CSR write
    always_comb begin
        illegal     = commit_valid && (op != CSR_OP_NONE) && !addr_ok;
        ok          = commit_valid && rst_n && !illegal;
        irq_take    = ok && st_mie_q && mie_q[MIE_MTIE_BIT] && irq_timer;
        ecall_take  = ok && ecall && !irq_take;
        trap        = irq_take || ecall_take;
        mret_take   = ok && mret && !trap;
        case (op)
            CSR_OP_RW: wval = csr_wsrc;
            CSR_OP_RS: wval = old_val | csr_wsrc;
            CSR_OP_RC: wval = old_val & ~csr_wsrc;
            default:   wval = old_val;
        endcase
        do_write    = ok && !trap && !mret_take && (op != CSR_OP_NONE)
                      && ((op == CSR_OP_RW) || (csr_wsrc != '0));
        redirect    = trap || mret_take;
        redirect_pc = '0;
        if (trap)           redirect_pc = {mtvec_q[XLEN-1:2], 2'b00};
        else if (mret_take) redirect_pc = mepc_q;
    end

    always_comb begin
        mcause_irq             = XLEN'(MCAUSE_M_TIMER);
        mcause_irq[XLEN-1]     = 1'b1;
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (trap) begin
            mepc_d    = pc;
            mcause_d  = irq_take ? mcause_irq : XLEN'(MCAUSE_ECALL_M);
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
        end else if (mret_take) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end else if (do_write) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    st_mie_d  = wval[MSTATUS_MIE_BIT];
                    st_mpie_d = wval[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = wval;
                CSR_MTVEC:    mtvec_d    = wval;
                CSR_MSCRATCH: mscratch_d = wval;
                CSR_MEPC:     mepc_d     = wval;
                CSR_MCAUSE:   mcause_d   = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    // RV32 drives the same word to both halves; the half strobes pick one
    assign cnt_wdata      = (XLEN == 64) ? CNT_W'(wval) : {32'(wval), 32'(wval)};
    assign mcycle_wr_lo   = do_write && (csr_addr == CSR_MCYCLE);
    assign mcycle_wr_hi   = do_write && (csr_addr == cycle_hi_addr);
    assign minstret_wr_lo = do_write && (csr_addr == CSR_MINSTRET);
    assign minstret_wr_hi = do_write && (csr_addr == instret_hi_addr);

    if (HAS_COUNTERS != 0) begin : g_cnt
        ysyx_23060184_csr_counter u_mcycle (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (1'b1),
            .wr_lo (mcycle_wr_lo),
            .wr_hi (mcycle_wr_hi),
            .wdata (cnt_wdata),
            .count (mcycle)
        );
        ysyx_23060184_csr_counter u_minstret (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (ok && !trap),
            .wr_lo (minstret_wr_lo),
            .wr_hi (minstret_wr_hi),
            .wdata (cnt_wdata),
            .count (minstret)
        );
    end else begin : g_no_cnt
        assign mcycle   = '0;
        assign minstret = '0;
    end

endmodule
